relu_maxpool_stream: RTL

Sequential post-processing stage directly downstream of the convolution filter. Accepts one complete convolution output feature map as a parallel array of 32-bit words through a valid/ready handshake, applies ReLU and max pooling window by window, and streams the pooled results out one word per handshake in row-major order. It decouples the combinational convolution array from the serial consumer and throttles frames so only one map is in flight.

---
 rtl/relu_maxpool_stream_if.sv | 38 +++
 rtl/relu_maxpool_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_stream_if.sv
// Handshake bundle between the convolution array, the ReLU/max-pool stage and the serial consumer.
// The parallel map enters as one word per element; pooled results leave one word per handshake.
interface relu_maxpool_stream_if #(
  parameter int map_size = 3
);
  localparam int N_ELEMS = map_size * map_size;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data [N_ELEMS];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_index;
  logic        out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_index,
    output out_last
  );
endinterface

// File: rtl/relu_maxpool_stream.sv
// Captures one convolution feature map, then walks each pooling window one element per cycle,
// keeping a signed running maximum seeded with 0 so the result is ReLU(max(window)).
module relu_maxpool_stream #(
  parameter int map_size    = 3,
  parameter int pool_size   = 2,
  parameter int pool_stride = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  relu_maxpool_stream_if.slave  bus
);

  localparam int N_ELEMS  = map_size * map_size;
  localparam int OUT_SIZE = (map_size - pool_size) / pool_stride + 1;
  localparam int ADDR_W   = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
  localparam int CNT_W    = $clog2(map_size + 1);

  localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(OUT_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(pool_size - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] wr_reg, wr_next;
  logic [CNT_W-1:0] wc_reg, wc_next;
  logic [CNT_W-1:0] kr_reg, kr_next;
  logic [CNT_W-1:0] kc_reg, kc_next;
  logic [31:0]      acc_reg, acc_next;
  logic             in_ready_reg, in_ready_next;
  logic             out_valid_reg, out_valid_next;
  logic [31:0]      out_data_reg, out_data_next;
  logic [15:0]      out_index_reg, out_index_next;
  logic             out_last_reg, out_last_next;
  logic             capture;

  logic [31:0]      map_reg [N_ELEMS];

  int               elem_row;
  int               elem_col;
  logic [ADDR_W-1:0] elem_addr;
  logic [31:0]      elem;
  logic [31:0]      acc_max;
  logic             window_done;
  logic             win_last;
  logic [15:0]      win_index;

  // Map storage is deliberately left out of reset; it is always rewritten before use.
  generate
    for (genvar gi = 0; gi < N_ELEMS; gi++) begin : g_map
      always_ff @(posedge clk) begin
        if (capture) begin
          map_reg[gi] <= bus.in_data[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    elem_row    = int'(wr_reg) * pool_stride + int'(kr_reg);
    elem_col    = int'(wc_reg) * pool_stride + int'(kc_reg);
    elem_addr   = ADDR_W'(elem_row * map_size + elem_col);
    elem        = map_reg[elem_addr];
    acc_max     = ($signed(elem) > $signed(acc_reg)) ? elem : acc_reg;
    window_done = (kr_reg == LAST_K) && (kc_reg == LAST_K);
    win_last    = (wr_reg == LAST_WIN) && (wc_reg == LAST_WIN);
    win_index   = 16'(int'(wr_reg) * OUT_SIZE + int'(wc_reg));
  end

  always_comb begin
    state_next     = state_reg;
    wr_next        = wr_reg;
    wc_next        = wc_reg;
    kr_next        = kr_reg;
    kc_next        = kc_reg;
    acc_next       = acc_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_index_next = out_index_reg;
    out_last_next  = out_last_reg;
    capture        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_reg) begin
          capture       = 1'b1;
          wr_next       = '0;
          wc_next       = '0;
          kr_next       = '0;
          kc_next       = '0;
          acc_next      = '0;
          in_ready_next = 1'b0;
          state_next    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        acc_next = acc_max;
        if (kc_reg == LAST_K) begin
          kc_next = '0;
          kr_next = kr_reg + 1'b1;
        end else begin
          kc_next = kc_reg + 1'b1;
        end
        // The last element's contribution goes straight into the output register.
        if (window_done) begin
          kr_next        = '0;
          kc_next        = '0;
          state_next     = ST_EMIT;
          out_valid_next = 1'b1;
          out_data_next  = acc_max;
          out_index_next = win_index;
          out_last_next  = win_last;
        end
      end

      ST_EMIT: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          if (out_last_reg) begin
            in_ready_next = 1'b1;
            state_next    = ST_IDLE;
          end else begin
            if (wc_reg == LAST_WIN) begin
              wc_next = '0;
              wr_next = wr_reg + 1'b1;
            end else begin
              wc_next = wc_reg + 1'b1;
            end
            acc_next   = '0;
            kr_next    = '0;
            kc_next    = '0;
            state_next = ST_SCAN;
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        in_ready_next  = 1'b1;
        out_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      wr_reg        <= '0;
      wc_reg        <= '0;
      kr_reg        <= '0;
      kc_reg        <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_reg        <= wr_next;
      wc_reg        <= wc_next;
      kr_reg        <= kr_next;
      kc_reg        <= kc_next;
      acc_reg       <= acc_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_index_reg <= out_index_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_index = out_index_reg;
  assign bus.out_last  = out_last_reg;

endmodule
